// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - blocking single-outstanding load/store execution stage
package lsu_mem_pkg;

    localparam logic [1:0] MF_NM = 2'd0;
    localparam logic [1:0] MF_LD = 2'd1;
    localparam logic [1:0] MF_ST = 2'd2;

    localparam logic [1:0] MS_B  = 2'd0;
    localparam logic [1:0] MS_H  = 2'd1;
    localparam logic [1:0] MS_W  = 2'd2;

    localparam logic       LX_Z  = 1'b0;
    localparam logic       LX_S  = 1'b1;

    typedef struct packed {
        logic [1:0] memfn;
        logic [1:0] memsz;
        logic       ldext;
    } mem_ctrl_sigs_t;

endpackage

module lsu_mem_stage
    import lsu_mem_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  mem_ctrl_sigs_t       in_ctrl,
    input  logic [31:0]          in_rs1,
    input  logic [31:0]          in_imm,
    input  logic [31:0]          in_rs2,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 flush,
    output logic                 dmem_read,
    output logic                 dmem_write,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    output logic [3:0]           dmem_mbe,
    input  logic                 dmem_resp,
    input  logic [31:0]          dmem_rdata,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_W-1:0]     wb_tag,
    output logic [31:0]          wb_data,
    output logic                 wb_misalign
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_DONE     = 2'd2,
        S_REQ_KILL = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;

    mem_ctrl_sigs_t ctrl_q;
    logic [1:0]     addr_lo_q;

    logic           accept;
    logic [31:0]    ea;
    logic           is_ld;
    logic           is_st;
    logic           misalign;
    logic           go_req;
    logic [3:0]     mbe_calc;
    logic [31:0]    wdata_calc;
    logic [31:0]    load_shift;
    logic [31:0]    load_result;

    assign in_ready = (state == S_IDLE);
    assign wb_valid = (state == S_DONE);

    assign accept   = in_valid & in_ready & ~flush;
    assign ea       = in_rs1 + in_imm;
    assign is_ld    = (in_ctrl.memfn == MF_LD);
    assign is_st    = (in_ctrl.memfn == MF_ST);
    // An unused size encoding is checked like a word so it can never slip through unaligned.
    assign misalign = ((in_ctrl.memsz == MS_H) & ea[0]) |
                      ((in_ctrl.memsz != MS_B) & (in_ctrl.memsz != MS_H) & (ea[1:0] != 2'b00));
    assign go_req   = (is_ld | is_st) & ~misalign;

    // Store lane data and byte enables; loads carry no enables since the cache returns the whole word.
    always_comb begin
        mbe_calc   = 4'b0000;
        wdata_calc = in_rs2 << {ea[1:0], 3'b000};
        if (is_st) begin
            case (in_ctrl.memsz)
                MS_B:    mbe_calc = 4'b0001 << ea[1:0];
                MS_H:    mbe_calc = ea[1] ? 4'b1100 : 4'b0011;
                default: mbe_calc = 4'b1111;
            endcase
        end
    end

    // Align the returned word to the accessed lane and extend to 32 bits; stores write back zero.
    always_comb begin
        load_shift  = dmem_rdata >> {addr_lo_q, 3'b000};
        load_result = 32'h0;
        if (ctrl_q.memfn == MF_LD) begin
            case (ctrl_q.memsz)
                MS_B:    load_result = (ctrl_q.ldext == LX_S) ? {{24{load_shift[7]}}, load_shift[7:0]}
                                                              : {24'h0, load_shift[7:0]};
                MS_H:    load_result = (ctrl_q.ldext == LX_S) ? {{16{load_shift[15]}}, load_shift[15:0]}
                                                              : {16'h0, load_shift[15:0]};
                default: load_result = load_shift;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush outranks every other event, but an issued request must see its response.
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: begin
                state_next = S_IDLE;
                if (accept) begin
                    state_next = go_req ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                state_next = S_REQ;
                if (flush) begin
                    state_next = dmem_resp ? S_IDLE : S_REQ_KILL;
                end else if (dmem_resp) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
                if (flush || wb_ready) begin
                    state_next = S_IDLE;
                end
            end
            S_REQ_KILL: begin
                state_next = dmem_resp ? S_IDLE : S_REQ_KILL;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Capture the op on accept, hold the cache request until its response, then latch the writeback record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            addr_lo_q   <= 2'b00;
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
            dmem_addr   <= 32'h0;
            dmem_wdata  <= 32'h0;
            dmem_mbe    <= 4'b0000;
            wb_tag      <= '0;
            wb_data     <= 32'h0;
            wb_misalign <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ctrl_q      <= in_ctrl;
                        addr_lo_q   <= ea[1:0];
                        wb_tag      <= in_tag;
                        wb_data     <= 32'h0;
                        wb_misalign <= (is_ld | is_st) & misalign;
                        if (go_req) begin
                            dmem_read  <= is_ld;
                            dmem_write <= is_st;
                            dmem_addr  <= {ea[31:2], 2'b00};
                            dmem_wdata <= wdata_calc;
                            dmem_mbe   <= mbe_calc;
                        end
                    end
                end
                S_REQ, S_REQ_KILL: begin
                    if (dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        dmem_addr  <= 32'h0;
                        dmem_wdata <= 32'h0;
                        dmem_mbe   <= 4'b0000;
                        if ((state == S_REQ) && !flush) begin
                            wb_data <= load_result;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;
    import lsu_mem_pkg::*;

    localparam int TAG_W = 6;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    mem_ctrl_sigs_t     in_ctrl;
    logic [31:0]        in_rs1;
    logic [31:0]        in_imm;
    logic [31:0]        in_rs2;
    logic [TAG_W-1:0]   in_tag;
    logic               flush;
    logic               dmem_read;
    logic               dmem_write;
    logic [31:0]        dmem_addr;
    logic [31:0]        dmem_wdata;
    logic [3:0]         dmem_mbe;
    logic               dmem_resp;
    logic [31:0]        dmem_rdata;
    logic               wb_valid;
    logic               wb_ready;
    logic [TAG_W-1:0]   wb_tag;
    logic [31:0]        wb_data;
    logic               wb_misalign;

    lsu_mem_stage #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_rs1(in_rs1), .in_imm(in_imm), .in_rs2(in_rs2), .in_tag(in_tag),
        .flush(flush),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_data(wb_data), .wb_misalign(wb_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fn;
        logic [1:0]  sz;
        logic        ext;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          delay;
        int          hold;
        logic        ex_rd;
        logic        ex_wr;
        logic [31:0] ex_addr;
        logic [3:0]  ex_mbe;
        logic [31:0] ex_wdata;
        logic [31:0] ex_data;
        logic        ex_mis;
    } vec_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             mis;
    } wb_t;

    wb_t  sb_q[$];
    vec_t vecs[14];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic vec_t mk(logic [1:0] fn, logic [1:0] sz, logic ext,
                                logic [31:0] rs1, logic [31:0] imm, logic [31:0] rs2,
                                logic [31:0] rdata, int delay, int hold,
                                logic rd, logic wr, logic [31:0] addr, logic [3:0] mbe,
                                logic [31:0] wdata, logic [31:0] data, logic mis);
        vec_t v;
        v.fn = fn; v.sz = sz; v.ext = ext; v.rs1 = rs1; v.imm = imm; v.rs2 = rs2;
        v.rdata = rdata; v.delay = delay; v.hold = hold; v.ex_rd = rd; v.ex_wr = wr;
        v.ex_addr = addr; v.ex_mbe = mbe; v.ex_wdata = wdata; v.ex_data = data; v.ex_mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Any writeback with nothing expected on the scoreboard is an error.
    always @(negedge clk) begin
        if (rst_n && wb_valid && sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_wb: wb_valid=1 tag=0x%0h with empty scoreboard", wb_tag);
        end
    end

    task automatic finish_wb(input int hold);
        int  n;
        wb_t e;
        n = 0;
        while (!wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wb_valid_seen", wb_valid, 1);
        if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL sb_pop: got empty scoreboard expected a record");
            return;
        end
        e = sb_q[0];
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", wb_valid, 1);
            chk("hold_data", wb_data, e.data);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("wb_tag", wb_tag, e.tag);
        chk("wb_data", wb_data, e.data);
        chk("wb_misalign", wb_misalign, e.mis);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        void'(sb_q.pop_front());
        chk("wb_drop", wb_valid, 0);
        chk("in_ready_after_wb", in_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input logic [TAG_W-1:0] tag);
        wb_t e;
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_ctrl  = '{memfn: v.fn, memsz: v.sz, ldext: v.ext};
        in_rs1   = v.rs1;
        in_imm   = v.imm;
        in_rs2   = v.rs2;
        in_tag   = tag;
        e.tag = tag; e.data = v.ex_data; e.mis = v.ex_mis;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_busy", in_ready, 0);
        chk("dmem_read", dmem_read, v.ex_rd);
        chk("dmem_write", dmem_write, v.ex_wr);
        if (v.ex_rd || v.ex_wr) begin
            chk("dmem_addr", dmem_addr, v.ex_addr);
            chk("dmem_mbe", dmem_mbe, v.ex_mbe);
            chk("dmem_wdata", dmem_wdata, v.ex_wdata);
            chk("wb_early", wb_valid, 0);
            for (int i = 0; i < v.delay; i++) begin
                @(negedge clk);
                chk("req_held_rd", dmem_read, v.ex_rd);
                chk("req_held_wr", dmem_write, v.ex_wr);
                chk("req_held_addr", dmem_addr, v.ex_addr);
            end
            dmem_resp  = 1'b1;
            dmem_rdata = v.rdata;
            @(negedge clk);
            dmem_resp  = 1'b0;
            dmem_rdata = 32'h0;
            chk("req_drop_rd", dmem_read, 0);
            chk("req_drop_wr", dmem_write, 0);
        end
        chk("wb_latency", wb_valid, 1);
        finish_wb(v.hold);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_rs1 = 0; in_imm = 0; in_rs2 = 0;
        in_tag = 0; flush = 1'b0; dmem_resp = 1'b0; dmem_rdata = 0; wb_ready = 1'b0;

        vecs[0]  = mk(MF_LD, MS_B, LX_S, 32'h1000, 32'd3, 0, 32'h80FF_1234, 1, 0, 1, 0, 32'h1000, 4'b0000, 0, 32'hFFFF_FF80, 0);
        vecs[1]  = mk(MF_LD, MS_H, LX_Z, 32'h2000, 32'd2, 0, 32'hBEEF_0000, 0, 3, 1, 0, 32'h2000, 4'b0000, 0, 32'h0000_BEEF, 0);
        vecs[2]  = mk(MF_LD, MS_H, LX_S, 32'h2000, 32'd2, 0, 32'hBEEF_0000, 2, 0, 1, 0, 32'h2000, 4'b0000, 0, 32'hFFFF_BEEF, 0);
        vecs[3]  = mk(MF_ST, MS_B, LX_Z, 32'h3000, 32'd1, 32'hAABB_CCDD, 32'hFFFF_FFFF, 1, 0, 0, 1, 32'h3000, 4'b0010, 32'hBBCC_DD00, 0, 0);
        vecs[4]  = mk(MF_LD, MS_W, LX_Z, 32'h4000, 32'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[5]  = mk(MF_NM, MS_W, LX_Z, 32'h4001, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(MF_LD, MS_B, LX_Z, 32'h5000, 32'd2, 0, 32'h1234_5678, 1, 0, 1, 0, 32'h5000, 4'b0000, 0, 32'h0000_0034, 0);
        vecs[7]  = mk(MF_ST, MS_H, LX_Z, 32'h6000, 32'd2, 32'h0000_ABCD, 0, 0, 0, 0, 1, 32'h6000, 4'b1100, 32'hABCD_0000, 0, 0);
        vecs[8]  = mk(MF_ST, MS_W, LX_Z, 32'h7000, 32'd0, 32'hDEAD_BEEF, 0, 3, 0, 0, 1, 32'h7000, 4'b1111, 32'hDEAD_BEEF, 0, 0);
        vecs[9]  = mk(MF_LD, MS_W, LX_S, 32'h8010, 32'hFFFF_FFF0, 0, 32'hCAFE_F00D, 1, 1, 1, 0, 32'h8000, 4'b0000, 0, 32'hCAFE_F00D, 0);
        vecs[10] = mk(MF_ST, MS_H, LX_Z, 32'h9000, 32'd1, 32'h0000_1111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[11] = mk(MF_LD, MS_B, LX_S, 32'hD000, 32'd0, 0, 32'hFFFF_FF7F, 0, 0, 1, 0, 32'hD000, 4'b0000, 0, 32'h0000_007F, 0);
        vecs[12] = mk(MF_LD, MS_H, LX_S, 32'hE000, 32'd0, 0, 32'h1234_8001, 1, 0, 1, 0, 32'hE000, 4'b0000, 0, 32'hFFFF_8001, 0);
        vecs[13] = mk(MF_ST, MS_B, LX_Z, 32'hF000, 32'd3, 32'h0000_00EE, 0, 0, 0, 0, 1, 32'hF000, 4'b1000, 32'hEE00_0000, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_read", dmem_read, 0);
        chk("rst_write", dmem_write, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_mbe", dmem_mbe, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], TAG_W'(i + 1));
            @(negedge clk);
        end

        // Flush in IDLE blocks the accept.
        in_valid = 1'b1; flush = 1'b1;
        in_ctrl = '{memfn: MF_LD, memsz: MS_W, ldext: LX_Z}; in_rs1 = 32'hA000; in_imm = 0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_idle_ready", in_ready, 1);
        chk("fl_idle_read", dmem_read, 0);
        chk("fl_idle_wb", wb_valid, 0);

        // Store flushed two cycles before a late response, flush held over two cycles.
        in_valid = 1'b1; in_ctrl = '{memfn: MF_ST, memsz: MS_W, ldext: LX_Z};
        in_rs1 = 32'hA000; in_imm = 0; in_rs2 = 32'h1234_5678; in_tag = 6'd40;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fk_write0", dmem_write, 1);
        repeat (2) begin
            @(negedge clk);
            chk("fk_write_pre", dmem_write, 1);
        end
        flush = 1'b1;
        @(negedge clk);
        chk("fk_write_kill", dmem_write, 1);
        chk("fk_in_ready", in_ready, 0);
        chk("fk_wb", wb_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("fk_write_kill2", dmem_write, 1);
        chk("fk_wdata", dmem_wdata, 32'h1234_5678);
        chk("fk_in_ready2", in_ready, 0);
        dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("fk_write_drop", dmem_write, 0);
        chk("fk_idle", in_ready, 1);
        chk("fk_no_wb", wb_valid, 0);

        // Flush coinciding with the response goes straight to IDLE.
        in_valid = 1'b1; in_ctrl = '{memfn: MF_LD, memsz: MS_W, ldext: LX_Z};
        in_rs1 = 32'hB000; in_imm = 0; in_tag = 6'd41;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fr_read", dmem_read, 1);
        flush = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        flush = 1'b0; dmem_resp = 1'b0;
        chk("fr_read_drop", dmem_read, 0);
        chk("fr_idle", in_ready, 1);
        chk("fr_no_wb", wb_valid, 0);

        // Flush in DONE discards the pending writeback.
        begin
            wb_t e;
            e.tag = 6'd9; e.data = 0; e.mis = 0;
            sb_q.push_back(e);
        end
        in_valid = 1'b1; in_ctrl = '{memfn: MF_NM, memsz: MS_W, ldext: LX_Z}; in_tag = 6'd9;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fd_wb", wb_valid, 1);
        chk("fd_tag", wb_tag, 6'd9);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        void'(sb_q.pop_front());
        chk("fd_wb_drop", wb_valid, 0);
        chk("fd_idle", in_ready, 1);

        // Asynchronous reset mid-request, then a stray response in IDLE.
        in_valid = 1'b1; in_ctrl = '{memfn: MF_LD, memsz: MS_B, ldext: LX_S};
        in_rs1 = 32'hC000; in_imm = 32'd1; in_tag = 6'd33;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_read", dmem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_read0", dmem_read, 0);
        chk("ar_write0", dmem_write, 0);
        chk("ar_addr0", dmem_addr, 0);
        chk("ar_mbe0", dmem_mbe, 0);
        chk("ar_wdata0", dmem_wdata, 0);
        chk("ar_wb_valid0", wb_valid, 0);
        chk("ar_wb_data0", wb_data, 0);
        chk("ar_wb_tag0", wb_tag, 0);
        chk("ar_wb_mis0", wb_misalign, 0);
        chk("ar_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("stray_no_wb", wb_valid, 0);
        chk("stray_ready", in_ready, 1);
        chk("stray_read", dmem_read, 0);

        // The stage still works after reset.
        run_vec(vecs[0], 6'd50);

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Sequential load/store execution stage, fed by the register-read/decode stage.
- Accepts one decoded memory micro-op at a time: computes the effective address, issues a single word-aligned request with byte enables to the data cache, and holds it until the cache responds.
- Aligns and sign- or zero-extends load data, then presents one writeback record to the commit/writeback arbiter.
- Blocking, single outstanding access; flushable.

Parameters:
- TAG_W, 6, width of the ROB/destination tag carried alongside the op.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded memory op is present.
- in_ready  out  1  stage can accept an op this cycle.
- in_ctrl  in  mem_ctrl_sigs_t  {memfn, memsz, ldext} from the memory decoder.
- in_rs1  in  32  base register value.
- in_imm  in  32  sign-extended offset.
- in_rs2  in  32  store data, unaligned (byte/half in the low bits).
- in_tag  in  TAG_W  ROB tag.
- flush  in  1  kill all in-flight work.
- dmem_read  out  1  cache read request.
- dmem_write  out  1  cache write request.
- dmem_addr  out  32  word-aligned address, bits [1:0] = 0.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_mbe  out  4  byte enables.
- dmem_resp  in  1  one-cycle completion pulse.
- dmem_rdata  in  32  load word, valid with dmem_resp.
- wb_valid  out  1  writeback record valid.
- wb_ready  in  1  arbiter takes the record.
- wb_tag  out  TAG_W  tag of the completed op.
- wb_data  out  32  extended load result; 0 for stores and non-memory ops.
- wb_misalign  out  1  address misaligned; no memory access was made.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - REQ: request held.
  - DONE: wb_valid=1.
  - REQ_KILL: waiting for the response to a flushed request.
- Reset (async, rst_n=0): state=IDLE. All dmem_* outputs, wb_valid, wb_misalign, wb_data and wb_tag = 0. Internal registers = 0.
- Accept: occurs on in_valid & in_ready & ~flush.
  - Register addr = in_rs1 + in_imm (mod 2^32), plus ctrl, tag and rs2.
- Misalignment check:
  - memsz=h with addr[0]=1 is misaligned.
  - memsz=w with addr[1:0]≠0 is misaligned.
- Transitions out of IDLE on accept:
  - memfn=nm → DONE, wb_data=0, wb_misalign=0.
  - ld or st, misaligned → DONE, wb_misalign=1, wb_data=0, no dmem request.
  - ld or st, aligned → REQ, starting on the next cycle.
- REQ outputs:
  - dmem_read = (memfn==ld); dmem_write = (memfn==st).
  - dmem_addr = {addr[31:2], 2'b00}.
  - dmem_mbe: b → one-hot on addr[1:0]; h → 0011 or 1100 selected by addr[1]; w → 1111.
  - dmem_mbe = 0 for loads as well (the cache returns the full word).
  - dmem_wdata = rs2 << 8*addr[1:0].
  - All of the above are registered and held stable until dmem_resp.
- REQ exit: on dmem_resp, drop the request in the same edge and go to DONE.
  - Load result: sh = dmem_rdata >> 8*addr[1:0].
  - b: ldext s → sign-extend sh[7:0]; ldext z → zero-extend sh[7:0].
  - h: sign- or zero-extend sh[15:0] per ldext.
  - w: result = sh.
  - Stores: wb_data=0.
- DONE: on wb_ready → IDLE. The next op may be accepted one cycle later, so there is no IDLE bypass.
- Latency: an aligned access takes accept → request at +1 cycle; wb_valid is asserted the cycle after dmem_resp. nm and misaligned ops produce wb_valid at accept+1.
- Flush (has priority over every other event):
  - IDLE: no accept.
  - DONE: wb_valid drops and the state goes to IDLE.
  - REQ: the request cannot be retracted.
    - With no dmem_resp that cycle: go to REQ_KILL, keeping the request asserted.
    - With dmem_resp in the same cycle: go directly to IDLE with no writeback.
  - REQ_KILL: keep the request asserted until dmem_resp, then go to IDLE with no writeback. in_ready=0 throughout.
- Multiple flushes in REQ_KILL are harmless.
- Reset mid-request: drop everything immediately. A subsequent stray dmem_resp in IDLE is ignored.
- Unknown or illegal state decodes to IDLE.

Test Plan:
- lb, rs1=0x1000, imm=3, dmem_rdata=0x80FF_1234 → dmem_addr=0x1000, mbe=0000, read=1; wb_data=0xFFFF_FF80.
- lhu, addr=0x2002, rdata=0xBEEF_0000 → wb_data=0x0000_BEEF. Repeat with lh → wb_data=0xFFFF_BEEF.
- sb, addr=0x3001, rs2=0xAABB_CCDD → write=1, dmem_addr=0x3000, mbe=0010, wdata=0xBBCC_DD00; wb_data=0.
- lw, addr=0x4002 → no dmem_read at any cycle; wb_valid with wb_misalign=1 one cycle after accept.
- sw issued, flush asserted 2 cycles before dmem_resp (resp delayed 5 cycles) → write held until resp, in_ready=0, no wb_valid, IDLE the cycle after resp.
- Load completes with wb_ready held low for 3 cycles → wb_valid/wb_data stable, in_ready=0. rst_n pulsed low mid-REQ → all outputs 0 asynchronously.
